// File: rtl/alarm_set_pkg.sv
// alarm_set_pkg: definitions shared by the alarm-set, clock and display blocks.
//   - FSM state encoding (numerically equal to the edit_field index)
//   - field index constants, BCD field limits
//   - bit-slice positions of the packed 24-bit HH:MM:SS BCD time
//   - helper that advances the edit field SET_H -> SET_M -> SET_S -> SET_H
package alarm_set_pkg;

    localparam logic [1:0] FIELD_IDLE = 2'd0;
    localparam logic [1:0] FIELD_HOUR = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    typedef enum logic [1:0] {
        StIdle = FIELD_IDLE,
        StSetH = FIELD_HOUR,
        StSetM = FIELD_MIN,
        StSetS = FIELD_SEC
    } state_e;

    localparam logic [7:0] HOUR_MAX   = 8'h23;
    localparam logic [7:0] MINSEC_MAX = 8'h59;

    // Two-digit field positions in the packed time
    localparam int unsigned HOUR_LSB = 16;
    localparam int unsigned MIN_LSB  = 8;
    localparam int unsigned SEC_LSB  = 0;

    // Single-digit positions in the packed time
    localparam int unsigned H_TENS_LSB = 20;
    localparam int unsigned H_ONES_LSB = 16;
    localparam int unsigned M_TENS_LSB = 12;
    localparam int unsigned M_ONES_LSB = 8;
    localparam int unsigned S_TENS_LSB = 4;
    localparam int unsigned S_ONES_LSB = 0;

    function automatic state_e next_set_state(input state_e s);
        case (s)
            StSetH:  return StSetM;
            StSetM:  return StSetS;
            default: return StSetH;
        endcase
    endfunction

endpackage

// File: rtl/bcd2_step.sv
// bcd2_step: combinational two-digit packed-BCD +1/-1 with wrap-around.
//   i_value  current two-digit BCD value
//   i_max    largest legal value of the field (e.g. 8'h23 or 8'h59)
//   i_inc    step up (wins over i_dec)
//   i_dec    step down
//   o_value  stepped value; i_value unchanged when neither step is requested
module bcd2_step (
    input  logic [7:0] i_value,
    input  logic [7:0] i_max,
    input  logic       i_inc,
    input  logic       i_dec,
    output logic [7:0] o_value
);

    logic [3:0] w_tens;
    logic [3:0] w_ones;

    assign w_tens = i_value[7:4];
    assign w_ones = i_value[3:0];

    always_comb begin
        o_value = i_value;
        if (i_inc) begin
            // >= so an out-of-range value still lands back on 00
            if (i_value >= i_max) begin
                o_value = 8'h00;
            end else if (w_ones == 4'd9) begin
                o_value = {w_tens + 4'd1, 4'd0};
            end else begin
                o_value = {w_tens, w_ones + 4'd1};
            end
        end else if (i_dec) begin
            if (i_value == 8'h00) begin
                o_value = i_max;
            end else if (w_ones == 4'd0) begin
                o_value = {w_tens - 4'd1, 4'd9};
            end else begin
                o_value = {w_tens, w_ones - 4'd1};
            end
        end
    end

endmodule

// File: rtl/alarm_set.sv
// alarm_set: alarm-time editor in front of the clock/alarm block.
//   clk, rst_n         clock, synchronous active-low reset
//   ALARM_R            alarm-edit level from the state controller
//   key_next/inc/dec/ok  single-cycle debounced key pulses
//   alarm_R            committed alarm, packed BCD HH:MM:SS
//   alarm_ready_R_clk  one-cycle strobe, aligned with the alarm_R update
//   edit_field         0 idle, 1 hours, 2 minutes, 3 seconds
//   edit_value         working value shown while editing
//   blink_mask         per-digit blank request, bit5 = h_tens .. bit0 = s_ones
module alarm_set
    import alarm_set_pkg::*;
#(
    parameter int unsigned BLINK_MAX = 24999999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ALARM_R,
    input  logic        key_next,
    input  logic        key_inc,
    input  logic        key_dec,
    input  logic        key_ok,
    output logic [23:0] alarm_R,
    output logic        alarm_ready_R_clk,
    output logic [1:0]  edit_field,
    output logic [23:0] edit_value,
    output logic [5:0]  blink_mask
);

    localparam int unsigned CntW = (BLINK_MAX > 0) ? $clog2(BLINK_MAX + 1) : 1;

    state_e          r_state;
    logic            r_alarm_prev;
    logic [23:0]     r_alarm;
    logic [23:0]     r_edit;
    logic            r_strobe;
    logic [CntW-1:0] r_blink_cnt;
    logic            r_blink_phase;

    logic [7:0]      w_field_val;
    logic [7:0]      w_field_max;
    logic [7:0]      w_field_new;
    logic [23:0]     w_edit_next;
    logic [5:0]      w_blink_mask;

    // Active-field select feeding the single stepper
    always_comb begin
        w_field_val = r_edit[HOUR_LSB +: 8];
        w_field_max = HOUR_MAX;
        case (r_state)
            StSetM: begin
                w_field_val = r_edit[MIN_LSB +: 8];
                w_field_max = MINSEC_MAX;
            end
            StSetS: begin
                w_field_val = r_edit[SEC_LSB +: 8];
                w_field_max = MINSEC_MAX;
            end
            default: ;
        endcase
    end

    bcd2_step u_step (
        .i_value (w_field_val),
        .i_max   (w_field_max),
        .i_inc   (key_inc),
        .i_dec   (key_dec),
        .o_value (w_field_new)
    );

    // Write the stepped field back; other fields untouched
    always_comb begin
        w_edit_next = r_edit;
        case (r_state)
            StSetH:  w_edit_next[HOUR_LSB +: 8] = w_field_new;
            StSetM:  w_edit_next[MIN_LSB +: 8]  = w_field_new;
            StSetS:  w_edit_next[SEC_LSB +: 8]  = w_field_new;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= StIdle;
            r_alarm_prev  <= 1'b0;
            r_alarm       <= '0;
            r_edit        <= '0;
            r_strobe      <= 1'b0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_alarm_prev <= ALARM_R;
            r_strobe     <= 1'b0;
            case (r_state)
                StIdle: begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= 1'b0;
                    if (ALARM_R && !r_alarm_prev) begin
                        r_state <= StSetH;
                        r_edit  <= r_alarm;
                    end
                end
                default: begin
                    // Any accepted event restarts the blink so the field shows at once
                    if (!ALARM_R) begin
                        r_state       <= StIdle;
                        r_blink_cnt   <= '0;
                        r_blink_phase <= 1'b0;
                    end else if (key_ok) begin
                        r_alarm       <= r_edit;
                        r_strobe      <= 1'b1;
                        r_state       <= StIdle;
                        r_blink_cnt   <= '0;
                        r_blink_phase <= 1'b0;
                    end else if (key_next) begin
                        r_state       <= next_set_state(r_state);
                        r_blink_cnt   <= '0;
                        r_blink_phase <= 1'b0;
                    end else if (key_inc || key_dec) begin
                        r_edit        <= w_edit_next;
                        r_blink_cnt   <= '0;
                        r_blink_phase <= 1'b0;
                    end else if (r_blink_cnt == CntW'(BLINK_MAX)) begin
                        r_blink_cnt   <= '0;
                        r_blink_phase <= ~r_blink_phase;
                    end else begin
                        r_blink_cnt   <= r_blink_cnt + CntW'(1);
                    end
                end
            endcase
        end
    end

    always_comb begin
        w_blink_mask = '0;
        if (r_blink_phase) begin
            case (r_state)
                StSetH:  w_blink_mask = 6'b110000;
                StSetM:  w_blink_mask = 6'b001100;
                StSetS:  w_blink_mask = 6'b000011;
                default: w_blink_mask = '0;
            endcase
        end
    end

    assign alarm_R           = r_alarm;
    assign alarm_ready_R_clk = r_strobe;
    assign edit_field        = r_state;
    assign edit_value        = r_edit;
    assign blink_mask        = w_blink_mask;

endmodule
